// File: rtl/le_cfg_pkg.sv
// Shared constants, function codes, FSM state encodings and the select range check
// for the logic-element configuration loader.
package le_cfg_pkg;

    localparam int FUNC_W = 3;
    localparam int SEL_W  = 6;
    localparam int CFG_W  = 15;

    localparam int FUNC_LSB  = 0;
    localparam int SEL_A_LSB = 3;
    localparam int SEL_B_LSB = 9;

    typedef enum logic [FUNC_W-1:0] {
        FN_AND  = 3'd0,
        FN_OR   = 3'd1,
        FN_NOT  = 3'd2,
        FN_XOR  = 3'd3,
        FN_XNOR = 3'd4,
        FN_NAND = 3'd5,
        FN_NOR  = 3'd6,
        FN_BUF  = 3'd7
    } func_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    // Every 3-bit function code is defined, so only the two selects can be out of range.
    function automatic logic cfg_elem_ok(input logic [CFG_W-1:0] cfg, input int num_inputs);
        logic [SEL_W-1:0] w_sel_a;
        logic [SEL_W-1:0] w_sel_b;
        w_sel_a = cfg[SEL_A_LSB +: SEL_W];
        w_sel_b = cfg[SEL_B_LSB +: SEL_W];
        return (int'({26'd0, w_sel_a}) < num_inputs) && (int'({26'd0, w_sel_b}) < num_inputs);
    endfunction

endpackage

// File: rtl/le_cfg_shifter.sv
// Shadow shift register and accepted-bit counter for the configuration loader.
// o_full flags that the bit being shifted this cycle completes the frame.
module le_cfg_shifter #(
    parameter int TOTAL_W = 120,
    parameter int CNT_W   = $clog2(TOTAL_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_bit,
    output logic [TOTAL_W-1:0] o_shadow,
    output logic               o_full
);

    logic [TOTAL_W-1:0] r_shadow;
    logic [CNT_W-1:0]   r_count;

    // MSB-first: the first bit received ends up in the top position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (i_shift) begin
            r_shadow <= {r_shadow[TOTAL_W-2:0], i_bit};
            r_count  <= r_count + 1'b1;
        end
    end

    assign o_shadow = r_shadow;
    assign o_full   = i_shift && (r_count == CNT_W'(TOTAL_W - 1));

endmodule

// File: rtl/le_config_loader.sv
// Serial configuration loader: shift a frame in, commit it atomically, settle, flag valid.
// Define LE_CFG_RANGE_CHECK_EN to reject frames whose selects exceed NUM_INPUTS-1.
module le_config_loader
    import le_cfg_pkg::*;
#(
    parameter int NUM_LE        = 8,
    parameter int NUM_INPUTS    = 37,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic [NUM_LE*CFG_W-1:0] active_cfg,
    output logic                    cfg_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int TOTAL_W = NUM_LE * CFG_W;
    localparam int ST_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    logic [1:0]         r_state;
    logic [TOTAL_W-1:0] r_active;
    logic               r_valid;
    logic               r_done;
    logic [ST_W-1:0]    r_settle;

    logic [TOTAL_W-1:0] w_shadow;
    logic               w_full;
    logic               w_accept;
    logic               w_clear;

    // abort wins over a bit offered in the same cycle, so that bit is never shifted.
    assign w_accept = (r_state == ST_SHIFT) && bit_valid && !abort;
    assign w_clear  = ((r_state == ST_IDLE) && start) || ((r_state == ST_SHIFT) && abort);

    le_cfg_shifter #(
        .TOTAL_W (TOTAL_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_shift  (w_accept),
        .i_bit    (bit_in),
        .o_shadow (w_shadow),
        .o_full   (w_full)
    );

`ifdef LE_CFG_RANGE_CHECK_EN
    logic r_err;
    logic w_cfg_ok;

    always_comb begin
        w_cfg_ok = 1'b1;
        for (int i = 0; i < NUM_LE; i++) begin
            if (!cfg_elem_ok(w_shadow[i*CFG_W +: CFG_W], NUM_INPUTS)) begin
                w_cfg_ok = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_active <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_settle <= '0;
`ifdef LE_CFG_RANGE_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LE_CFG_RANGE_CHECK_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_full) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
`ifdef LE_CFG_RANGE_CHECK_EN
                    if (!w_cfg_ok) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else
`endif
                    begin
                        r_active <= w_shadow;
                        r_settle <= '0;
                        // With no settle interval the new frame is usable straight away.
                        if (SETTLE_CYCLES == 0) begin
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign active_cfg = r_active;
    assign cfg_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign bit_ready  = (r_state == ST_SHIFT);
    assign done       = r_done;
`ifdef LE_CFG_RANGE_CHECK_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_le_config_loader.sv
// Directed bench for le_config_loader (NUM_LE = 2, SETTLE_CYCLES = 4) with a
// per-cycle timeline model and literal checks on latency, abort, start-while-busy and reset.
module tb_le_config_loader;

    localparam int NUM_LE     = 2;
    localparam int NUM_INPUTS = 37;
    localparam int SETTLE     = 4;
    localparam int TOTAL_W    = NUM_LE * 15;

`ifdef LE_CFG_RANGE_CHECK_EN
    localparam logic [TOTAL_W-1:0] BASIC_EXP   = 30'h0;
    localparam logic               BASIC_VALID = 1'b0;
`else
    localparam logic [TOTAL_W-1:0] BASIC_EXP   = 30'h1234_5678;
    localparam logic               BASIC_VALID = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst, start, abort, bit_in, bit_valid;
    logic bit_ready, cfg_valid, busy, done, err;
    logic [TOTAL_W-1:0] active_cfg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    le_config_loader #(
        .NUM_LE        (NUM_LE),
        .NUM_INPUTS    (NUM_INPUTS),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .active_cfg (active_cfg),
        .cfg_valid  (cfg_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    logic               m_loading = 1'b0;
    bit                 m_q[$];
    int                 m_since = -1;   // edges since the frame's last bit; -1 when no frame pending
    logic [TOTAL_W-1:0] m_shadow = '0;
    logic [TOTAL_W-1:0] m_active = '0;
    logic               m_valid = 1'b0;
    logic               m_done = 1'b0;
    logic               m_err = 1'b0;

    function automatic bit frame_ok(input logic [TOTAL_W-1:0] f);
`ifdef LE_CFG_RANGE_CHECK_EN
        logic [14:0] c;
        for (int e = 0; e < NUM_LE; e++) begin
            c = f[e*15 +: 15];
            if (int'({26'd0, c[8:3]}) >= NUM_INPUTS || int'({26'd0, c[14:9]}) >= NUM_INPUTS) return 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_loading = 1'b0;
            m_q.delete();
            m_since = -1;
            m_active = '0;
            m_valid = 1'b0;
            m_done = 1'b0;
            m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err = 1'b0;
            if (m_since >= 0) begin
                m_since++;
                if (m_since == 1) begin
                    if (!frame_ok(m_shadow)) begin
                        m_err = 1'b1;
                        m_since = -1;
                    end else begin
                        m_active = m_shadow;
                        m_valid = 1'b0;
                    end
                end
                if (m_since == SETTLE + 1) begin
                    m_valid = 1'b1;
                    m_done = 1'b1;
                    m_since = -1;
                end
            end else if (m_loading) begin
                if (abort) begin
                    m_loading = 1'b0;
                    m_q.delete();
                end else if (bit_valid) begin
                    m_q.push_back(bit_in);
                    if (m_q.size() == TOTAL_W) begin
                        for (int i = 0; i < TOTAL_W; i++) m_shadow[TOTAL_W-1-i] = m_q[i];
                        m_loading = 1'b0;
                        m_since = 0;
                        m_q.delete();
                    end
                end
            end else if (start) begin
                m_loading = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = -1;
    int act_cyc = -1;
    logic [TOTAL_W-1:0] prev_active = '0;

    initial forever begin
        @(negedge clk);
        chk("active_cfg", 64'(active_cfg), 64'(m_active));
        chk("cfg_valid", 64'(cfg_valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(m_loading || m_since >= 0));
        chk("bit_ready", 64'(bit_ready), 64'(m_loading));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err === 1'b1) err_cnt++;
        if (active_cfg !== prev_active) act_cyc = cyc;
        prev_active = active_cfg;
    end

    // ---------------- drivers ----------------
    task automatic load(input logic [TOTAL_W-1:0] data, input bit stall, input int abort_at,
                        input int start_at, output int acc, output int last_cyc);
        acc = 0;
        last_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && acc < TOTAL_W; k++) begin
            bit_valid = stall ? (k % 2 == 0) : 1'b1;
            bit_in = data[TOTAL_W-1-acc];
            start = (start_at >= 0) && (acc == start_at);
            abort = (acc == abort_at);
            if (abort) begin
                @(negedge clk);
                abort = 1'b0;
                bit_valid = 1'b0;
                return;
            end
            if (bit_valid && bit_ready) begin
                acc++;
                last_cyc = cyc;
            end
            @(negedge clk);
        end
        bit_valid = 1'b0;
        start = 1'b0;
        chk("load_bits_accepted", 64'(acc), 64'(TOTAL_W));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (!busy) return;
        end
        chk("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_active"}, 64'(active_cfg), 64'(0));
        chk({tag, "_valid"}, 64'(cfg_valid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'(bit_ready), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [TOTAL_W-1:0] d_ok1, d_ok2, d_bad40, d_ok36;
    int acc, lc, d0, e0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        d_ok1   = {6'd5, 6'd17, 3'd3, 6'd36, 6'd0, 3'd7};
        d_ok2   = {6'd0, 6'd36, 3'd1, 6'd12, 6'd33, 3'd5};
        d_bad40 = {6'd40, 6'd1, 3'd0, 6'd2, 6'd3, 3'd1};
        d_ok36  = {6'd36, 6'd1, 3'd0, 6'd2, 6'd3, 3'd1};
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic continuous load
        d0 = done_cnt;
        load(30'h1234_5678, 1'b0, -1, -1, acc, lc);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("basic_active", 64'(active_cfg), 64'(BASIC_EXP));
        chk("basic_model_pin", 64'(m_active), 64'(BASIC_EXP));
        chk("basic_valid", 64'(cfg_valid), 64'(BASIC_VALID));
`ifndef LE_CFG_RANGE_CHECK_EN
        chk("basic_active_latency", 64'(act_cyc - lc), 64'(2));
        chk("basic_done_latency", 64'(done_cyc - lc), 64'(2 + SETTLE));
        chk("basic_done_pulses", 64'(done_cnt - d0), 64'(1));
`endif

        // Stalled stream
        d0 = done_cnt;
        load(30'h1234_5678, 1'b1, -1, -1, acc, lc);
        chk("stall_accepted", 64'(acc), 64'(30));
        wait_idle();
        #1;
        chk("stall_active", 64'(active_cfg), 64'(BASIC_EXP));
        chk("stall_valid", 64'(cfg_valid), 64'(BASIC_VALID));

        // Abort after 17 bits, with bit_valid high in the abort cycle
        d0 = done_cnt;
        load(30'h3FFF_FFFF, 1'b0, 17, -1, acc, lc);
        #1;
        chk("abort_accepted", 64'(acc), 64'(17));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_active", 64'(active_cfg), 64'(BASIC_EXP));
        chk("abort_valid", 64'(cfg_valid), 64'(BASIC_VALID));
        repeat (8) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));

        // start pulsed while busy at bit 10
        d0 = done_cnt;
        load(d_ok1, 1'b0, -1, 10, acc, lc);
        wait_idle();
        #1;
        chk("restart_ignored_active", 64'(active_cfg), 64'({6'd5, 6'd17, 3'd3, 6'd36, 6'd0, 3'd7}));
        chk("restart_ignored_done", 64'(done_cnt - d0), 64'(1));
        chk("restart_ignored_valid", 64'(cfg_valid), 64'(1));

        // Async reset mid-SHIFT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_shift");
        @(negedge clk);
        rst = 1'b0;
        bit_valid = 1'b0;
        load(d_ok2, 1'b0, -1, -1, acc, lc);
        wait_idle();
        #1;
        chk("after_rst_shift_active", 64'(active_cfg), 64'({6'd0, 6'd36, 3'd1, 6'd12, 6'd33, 3'd5}));
        chk("after_rst_shift_valid", 64'(cfg_valid), 64'(1));

        // Async reset mid-SETTLE
        load(d_ok1, 1'b0, -1, -1, acc, lc);
        repeat (3) @(negedge clk);
        #1;
        chk("settle_busy", 64'(busy), 64'(1));
        chk("settle_valid_low", 64'(cfg_valid), 64'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_values("rst_settle");
        @(negedge clk);
        rst = 1'b0;
        load(d_ok2, 1'b0, -1, -1, acc, lc);
        wait_idle();
        #1;
        chk("after_rst_settle_active", 64'(active_cfg), 64'({6'd0, 6'd36, 3'd1, 6'd12, 6'd33, 3'd5}));
        chk("after_rst_settle_valid", 64'(cfg_valid), 64'(1));

        // Element 1 sel_b = 40, then sel_b = 36
        d0 = done_cnt;
        e0 = err_cnt;
        load(d_bad40, 1'b0, -1, -1, acc, lc);
        wait_idle();
        repeat (2) @(negedge clk);
        #1;
`ifdef LE_CFG_RANGE_CHECK_EN
        chk("range40_err", 64'(err_cnt - e0), 64'(1));
        chk("range40_no_done", 64'(done_cnt - d0), 64'(0));
        chk("range40_active_kept", 64'(active_cfg), 64'({6'd0, 6'd36, 3'd1, 6'd12, 6'd33, 3'd5}));
`else
        chk("range40_no_err", 64'(err_cnt - e0), 64'(0));
        chk("range40_done", 64'(done_cnt - d0), 64'(1));
        chk("range40_active", 64'(active_cfg), 64'({6'd40, 6'd1, 3'd0, 6'd2, 6'd3, 3'd1}));
`endif
        chk("range40_valid", 64'(cfg_valid), 64'(1));

        d0 = done_cnt;
        e0 = err_cnt;
        load(d_ok36, 1'b0, -1, -1, acc, lc);
        wait_idle();
        #1;
        chk("range36_err", 64'(err_cnt - e0), 64'(0));
        chk("range36_done", 64'(done_cnt - d0), 64'(1));
        chk("range36_active", 64'(active_cfg), 64'({6'd36, 6'd1, 3'd0, 6'd2, 6'd3, 3'd1}));
        chk("range36_valid", 64'(cfg_valid), 64'(1));

        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
